// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundle of every signal between the two bus masters, the
// arbiter and the data memory.
//   slave  modport : arbiter side (takes requests and dm_dout, drives
//                    ack/err/rdata, the memory command and busy)
//   master modport : environment side (masters plus memory model)
// m0_* : CPU load/store port, m1_* : secondary master (DMA/debug),
// dm_* : memory command/response, busy : arbiter not idle.
interface dm_arbiter_if #(
  parameter int AW = 32
);
  logic          m0_req, m1_req;
  logic          m0_wr, m1_wr;
  logic [1:0]    m0_be, m1_be;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [31:0]   m0_pc;
  logic          m0_ack, m1_ack;
  logic          m0_err, m1_err;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          dm_wr;
  logic [1:0]    dm_be;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_din;
  logic [31:0]   dm_pc;
  logic [31:0]   dm_dout;
  logic          busy;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_be, m1_be, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_pc, dm_dout,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
           dm_wr, dm_be, dm_addr, dm_din, dm_pc, busy
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_be, m1_be, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_pc, dm_dout,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
           dm_wr, dm_be, dm_addr, dm_din, dm_pc, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter and sequencer between two bus masters and
// a data memory with a level-sensitive write port.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : dm_arbiter_if.slave (master requests, acks, memory command)
// Each access runs IDLE -> ACCESS (1 cycle, memory strobe) -> RESP (ack).
// From RESP the other master can be granted directly, so alternating
// masters complete one access every two cycles.
module dm_arbiter #(
  parameter int AW = 32
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Per-master views of the request ports, indexed by master number.
  logic [1:0]           req;
  logic [1:0]           wr_in;
  logic [1:0][1:0]      be_in;
  logic [1:0][AW-1:0]   addr_in;
  logic [1:0][31:0]     wdata_in;
  logic [1:0][31:0]     pc_in;
  logic [1:0]           err_in;

  assign req      = {bus.m1_req, bus.m0_req};
  assign wr_in    = {bus.m1_wr, bus.m0_wr};
  assign be_in    = {bus.m1_be, bus.m0_be};
  assign addr_in  = {bus.m1_addr, bus.m0_addr};
  assign wdata_in = {bus.m1_wdata, bus.m0_wdata};
  assign pc_in    = {32'd0, bus.m0_pc};  // m1 has no PC to trace

  // Command register: the winning request, held for the whole access.
  logic          cmd_wr_reg;
  logic [1:0]    cmd_be_reg;
  logic [AW-1:0] cmd_addr_reg;
  logic [31:0]   cmd_wdata_reg;
  logic [31:0]   cmd_pc_reg;
  logic          cmd_err_reg;
  logic          owner_reg;
  logic          last_grant_reg;
  logic          dm_wr_reg;

  logic          grant;
  logic          grant_sel;

  logic [1:0]       ack;
  logic [1:0]       err_out;
  logic [1:0][31:0] rdata_reg;

  // Legality check and response generation per master.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    // Byte accesses are always aligned; half needs addr[0]=0, word addr[1:0]=0.
    assign err_in[gi] = (be_in[gi] == 2'b11) ||
                        ((be_in[gi] == 2'b10) && addr_in[gi][0]) ||
                        ((be_in[gi] == 2'b00) && (addr_in[gi][1:0] != 2'b00));

    assign ack[gi]     = (state_reg == RESP) && (owner_reg == 1'(gi));
    assign err_out[gi] = ack[gi] && cmd_err_reg;

    // Load data is captured at the end of ACCESS and then held.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rdata_reg[gi] <= 32'd0;
      end else if ((state_reg == ACCESS) && (owner_reg == 1'(gi)) &&
                   !cmd_wr_reg && !cmd_err_reg) begin
        rdata_reg[gi] <= bus.dm_dout;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and grant decision.
  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          grant      = 1'b1;
          // On a tie the master that did not win last time goes first.
          grant_sel  = (&req) ? ~last_grant_reg : req[1];
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = RESP;
      end
      RESP: begin
        // The owner's req is still high while it sees ack, so only the
        // other master can be granted here.
        if (req[~owner_reg]) begin
          grant      = 1'b1;
          grant_sel  = ~owner_reg;
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command register, arbitration history and the write strobe. The strobe
  // is only ever set together with a grant, i.e. on entry to ACCESS, and
  // every ACCESS cycle is followed by RESP, so it lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_wr_reg     <= 1'b0;
      cmd_be_reg     <= 2'b00;
      cmd_addr_reg   <= '0;
      cmd_wdata_reg  <= 32'd0;
      cmd_pc_reg     <= 32'd0;
      cmd_err_reg    <= 1'b0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      dm_wr_reg      <= 1'b0;
    end else begin
      dm_wr_reg <= grant && wr_in[grant_sel] && !err_in[grant_sel];
      if (grant) begin
        cmd_wr_reg     <= wr_in[grant_sel];
        cmd_be_reg     <= be_in[grant_sel];
        cmd_addr_reg   <= addr_in[grant_sel];
        cmd_wdata_reg  <= wdata_in[grant_sel];
        cmd_pc_reg     <= pc_in[grant_sel];
        cmd_err_reg    <= err_in[grant_sel];
        owner_reg      <= grant_sel;
        last_grant_reg <= grant_sel;
      end
    end
  end

  assign bus.m0_ack   = ack[0];
  assign bus.m1_ack   = ack[1];
  assign bus.m0_err   = err_out[0];
  assign bus.m1_err   = err_out[1];
  assign bus.m0_rdata = rdata_reg[0];
  assign bus.m1_rdata = rdata_reg[1];
  assign bus.dm_wr    = dm_wr_reg;
  assign bus.dm_be    = cmd_be_reg;
  assign bus.dm_addr  = 32'(cmd_addr_reg);
  assign bus.dm_din   = cmd_wdata_reg;
  assign bus.dm_pc    = cmd_pc_reg;
  assign bus.busy     = (state_reg != IDLE);

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-master arbiter and sequencer in front of the data memory. It arbitrates between the CPU load/store port (m0) and a secondary bus master such as DMA or debug (m1) using round-robin, and registers the winning command. It drives a single-cycle, glitch-free write pulse into the memory's level-sensitive write port and returns registered read data with a one-cycle `ack`. Misaligned or malformed requests are rejected without touching memory.

## Interface
Parameters:
- `AW`, default 32: address width; memory word index taken from `addr[11:2]`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  request. Held high with the command stable until the matching `ack`.
- `m0_wr`, `m1_wr`  in  1  1 = store, 0 = load.
- `m0_be`, `m1_be`  in  2  size: 00 word, 01 byte, 10 half, 11 illegal.
- `m0_addr`, `m1_addr`  in  AW  byte address.
- `m0_wdata`, `m1_wdata`  in  32  store data, right-aligned.
- `m0_pc`  in  32  PC of the m0 access. m1 accesses forward 0.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  valid with `ack`; 1 = rejected, no memory access.
- `m0_rdata`, `m1_rdata`  out  32  raw memory word, valid with `ack` on loads. Holds its value otherwise.
- `dm_wr`  out  1  memory write enable. Registered output.
- `dm_be`  out  2  memory size code.
- `dm_addr`  out  32  memory byte address.
- `dm_din`  out  32  memory write data.
- `dm_pc`  out  32  PC forwarded for the memory's trace output.
- `dm_dout`  in  32  memory read word (combinational from `dm_addr`).
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any unmasked request is high, select a winner, load the command register (`wr`, `be`, `addr`, `wdata`, `pc`, owner, `err`), then go to ACCESS.
- Arbitration: with a single requester, that requester wins. With both requesting, the master that was not `last_grant` wins. `last_grant` updates on every grant and resets to 1, so m0 wins the first tie.
- An error is flagged for any of: `be`=11; half with `addr[0]`=1; word with `addr[1:0]`≠0. Byte accesses are always legal.
- ACCESS (exactly 1 cycle): `dm_wr`=1 only if `wr` & !`err`. At the end of the cycle, capture `dm_dout` into the owner's `rdata` if `!wr` & !`err`. Then go to RESP.
- RESP (1 cycle): assert the owner's `ack`, and its `err` if flagged.
  - The owner's `req` is masked this cycle.
  - If the other master is requesting, grant it directly: load the command register and go to ACCESS.
  - Otherwise go to IDLE.
- `dm_addr`, `dm_be`, `dm_din` and `dm_pc` always reflect the command register. They change only on a grant, so they are stable for the whole ACCESS cycle.
- Memory write pulse:
  - `dm_wr` is a flop set on entry to ACCESS and cleared on exit.
  - It is never high in IDLE or RESP.
  - It is never high for a rejected request.
- `rdata` is the raw 32-bit word. Byte/half extraction and sign-extension belong to the load unit.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `last_grant`=1.
  - `dm_wr`=0, all `ack`/`err`=0, `busy`=0.
  - `rdata`=0, command register=0 (so `dm_addr`, `dm_be`, `dm_din`, `dm_pc`=0).
  - An in-flight access is dropped with no `ack`. If reset asserts during ACCESS, `dm_wr` falls combinationally with reset.
- Latency: `req` sampled high in IDLE at edge N → ACCESS during cycle N+1 → `ack` during cycle N+2.
- Throughput:
  - Back-to-back alternating masters complete one access every 2 cycles.
  - The same master re-requesting pays the extra IDLE cycle, giving 3 cycles per access.
- A requester deasserting `req` before `ack` is illegal; behaviour is undefined. Benches must assert on it.
- Both `ack`s are never high in the same cycle.
- `busy`=1 in ACCESS and RESP.

## Test plan
- Reset, then m0 stores word `32'hDEADBEEF` at `0x10`. Expect:
  - `dm_wr` high for exactly 1 cycle with `dm_addr`=0x10 and `dm_din`=DEADBEEF.
  - `m0_ack` 2 cycles after the sampled `req`, with `err`=0.
- m1 loads word `0x10` after the previous store → `m1_ack` with `m1_rdata`=DEADBEEF and `dm_wr` never high.
- m0 and m1 request in the same cycle after reset, both holding `req`:
  - Grant order is m0, m1, m0, m1.
  - `ack`s arrive every 2 cycles.
  - The `ack`s never overlap.
- m0 stores a half at `0x13` and m1 stores with `be`=11 → both return `ack` with `err`=1, no `dm_wr` pulse, memory unchanged.
- m0 stores byte `8'hA5` at `0x21` → `dm_be`=01 and `dm_addr`=0x21 during the pulse; a follow-up word load of `0x20` returns `0x0000A500` (after a prior zero fill).
- Assert `reset` midway through an ACCESS cycle → `dm_wr` drops immediately, no `ack`, `busy`=0, and a subsequent request completes normally.
